fmac_pkt_fifo: RTL

Single-clock, parametrised frame FIFO for the LMAC datapath: the next generation of the 4Kx64 data FIFO, adding frame commit/discard, an end-of-frame sideband bit, almost-full/almost-empty thresholds, a selectable show-ahead read mode and a committed-frame counter. It sits between MAC receive parsing (which only learns a frame is bad at its end) and the host/TX side, which must see only complete, good frames.

---
 rtl/fmac_pkg.sv | 19 +
 rtl/fmac_pkt_fifo_sdpram.sv | 26 ++
 rtl/fmac_pkt_fifo.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fmac_pkg.sv
// rtl/fmac_pkg.sv - shared defaults and pointer helpers for the frame FIFO
package fmac_pkg;
  localparam int DEPTH_DEF = 4096;
  localparam int PTR_DEF   = 12;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

  // Caller truncates to its pointer width, which gives the modulo-2*DEPTH distance
  function automatic logic [31:0] ptr_diff(input logic [31:0] a, input logic [31:0] b);
    return a - b;
  endfunction
endpackage

// File: rtl/fmac_pkt_fifo_sdpram.sv
// rtl/fmac_pkt_fifo_sdpram.sv - simple dual-port RAM, one write port, registered read port
module fmac_sdpram #(
  parameter int DW = 65,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata_q
);
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the output register resets so q reads back 0 after aclr
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata_q <= '0;
    else if (re) rdata_q <= mem[raddr];
  end
endmodule

// File: rtl/fmac_pkt_fifo.sv
// rtl/fmac_pkt_fifo.sv - frame FIFO with commit/discard, overflow recovery and optional show-ahead
module fmac_pkt_fifo
  import fmac_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int PTR       = PTR_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int AFULL_TH  = 4032,
  parameter int AEMPTY_TH = 8,
  parameter int SHOWAHEAD = 0
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             wrreq,
  input  logic [WIDTH-1:0] data,
  input  logic             wreop,
  input  logic             wrdrop,
  output logic             wrfull,
  output logic             almost_full,
  output logic [PTR:0]     wrusedw,
  output logic             ovf,
  input  logic             rdreq,
  output logic [WIDTH-1:0] q,
  output logic             q_eop,
  output logic             rdempty,
  output logic             almost_empty,
  output logic [PTR:0]     rdusedw,
  output logic [PTR:0]     pkt_cnt
);
  localparam logic [PTR:0] PTR_ONE   = {{PTR{1'b0}}, 1'b1};
  localparam logic [PTR:0] DEPTH_V   = (PTR+1)'(DEPTH);
  localparam logic [PTR:0] AFULL_V   = (PTR+1)'(AFULL_TH);
  localparam logic [PTR:0] AEMPTY_V  = (PTR+1)'(AEMPTY_TH);

  logic [PTR:0] wptr_q, wptr_d, cptr_q, cptr_d, rptr_q, rptr_d, fptr_q, fptr_d;
  logic [PTR:0] pkt_cnt_q, pkt_cnt_d;
  logic         ovf_flag_q, ovf_flag_d, ovf_q, ovf_d;
  logic         head_q, head_d, fresh_q, fresh_d;
  logic         ram_we, ram_re, commit, consume, dec, pend;
  logic [WIDTH:0] ram_rdata;

  assign wrusedw      = (PTR+1)'(ptr_diff(32'(wptr_q), 32'(rptr_q)));
  assign rdusedw      = (PTR+1)'(ptr_diff(32'(cptr_q), 32'(rptr_q)));
  assign wrfull       = (wrusedw == DEPTH_V);
  assign almost_full  = (wrusedw >= AFULL_V);
  assign almost_empty = (rdusedw <= AEMPTY_V);
  assign rdempty      = (SHOWAHEAD != 0) ? !head_q : (rdusedw == '0);
  assign q            = ram_rdata[WIDTH-1:0];
  assign q_eop        = ram_rdata[WIDTH];
  assign ovf          = ovf_q;
  // Normal mode learns the eop bit one cycle after the read; pend folds it in early
  assign pend         = fresh_q && ram_rdata[WIDTH];
  assign pkt_cnt      = (SHOWAHEAD != 0) ? pkt_cnt_q : (pkt_cnt_q - {{PTR{1'b0}}, pend});

  always_comb begin
    wptr_d     = wptr_q;
    cptr_d     = cptr_q;
    ovf_flag_d = ovf_flag_q;
    ovf_d      = 1'b0;
    ram_we     = 1'b0;
    commit     = 1'b0;
    if (ovf_flag_q || (wrreq && wrfull)) begin
      if (wrdrop || (wrreq && wreop)) begin
        wptr_d     = cptr_q;
        ovf_flag_d = 1'b0;
        ovf_d      = 1'b1;
      end else begin
        ovf_flag_d = 1'b1;
      end
    end else if (wrdrop) begin
      wptr_d = cptr_q;
    end else if (wrreq) begin
      ram_we = 1'b1;
      wptr_d = wptr_q + PTR_ONE;
      if (wreop) begin
        cptr_d = wptr_q + PTR_ONE;
        commit = 1'b1;
      end
    end
  end

  // fptr is the RAM fetch address; it runs ahead of rptr only in show-ahead mode
  always_comb begin
    rptr_d  = rptr_q;
    fptr_d  = fptr_q;
    head_d  = head_q;
    ram_re  = 1'b0;
    consume = 1'b0;
    dec     = 1'b0;
    fresh_d = 1'b0;
    if (SHOWAHEAD != 0) begin
      consume = rdreq && head_q;
      dec     = consume && ram_rdata[WIDTH];
      if (consume) rptr_d = rptr_q + PTR_ONE;
      if ((fptr_q != cptr_q) && (!head_q || rdreq)) begin
        ram_re = 1'b1;
        fptr_d = fptr_q + PTR_ONE;
        head_d = 1'b1;
      end else if (consume) begin
        head_d = 1'b0;
      end
    end else begin
      consume = rdreq && !rdempty;
      ram_re  = consume;
      fresh_d = consume;
      dec     = pend;
      if (consume) rptr_d = rptr_q + PTR_ONE;
      fptr_d = rptr_d;
    end
    pkt_cnt_d = pkt_cnt_q + {{PTR{1'b0}}, commit} - {{PTR{1'b0}}, dec};
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      wptr_q     <= '0;
      cptr_q     <= '0;
      rptr_q     <= '0;
      fptr_q     <= '0;
      pkt_cnt_q  <= '0;
      ovf_flag_q <= 1'b0;
      ovf_q      <= 1'b0;
      head_q     <= 1'b0;
      fresh_q    <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      cptr_q     <= cptr_d;
      rptr_q     <= rptr_d;
      fptr_q     <= fptr_d;
      pkt_cnt_q  <= pkt_cnt_d;
      ovf_flag_q <= ovf_flag_d;
      ovf_q      <= ovf_d;
      head_q     <= head_d;
      fresh_q    <= fresh_d;
    end
  end

  fmac_sdpram #(
    .DW(WIDTH + 1),
    .AW(clog2(DEPTH))
  ) u_ram (
    .clk    (clk),
    .rst    (aclr),
    .we     (ram_we),
    .waddr  (wptr_q[PTR-1:0]),
    .wdata  ({wreop, data}),
    .re     (ram_re),
    .raddr  (fptr_q[PTR-1:0]),
    .rdata_q(ram_rdata)
  );
endmodule
